// File: rtl/game_pkg.sv
// game_pkg: shared screen geometry, palette and pipe defaults.
// Also holds the pixel-coordinate types used by the pipe layer.
package game_pkg;

  localparam int H_ACTIVE = 800;
  localparam int V_ACTIVE = 600;

  localparam logic [11:0] COL_PIPE  = 12'h2A2;
  localparam logic [11:0] COL_SKY   = 12'h4CF;
  localparam logic [11:0] COL_BLANK = 12'h000;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  localparam int PIPE_X0  = 800;
  localparam int PIPE_GY0 = 250;
  localparam int GY_BASE  = 100;

  typedef logic [10:0] px_t;
  typedef logic [9:0]  gy_t;

  function automatic logic [11:0] right_edge(
    input px_t x,
    input int  w
  );
    return {1'b0, x} + 12'(w);
  endfunction

endpackage

// File: rtl/vga_if.sv
// vga_if: VGA timing bundle with pixel counters.
// The producer drives through out, the consumer samples through in.
interface vga_if;

  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;

  modport out (
    output hcount, hsync, hblnk,
    output vcount, vsync, vblnk
  );

  modport in (
    input hcount, hsync, hblnk,
    input vcount, vsync, vblnk
  );

endinterface

// File: rtl/lfsr16.sv
// lfsr16: free-running 16-bit Fibonacci LFSR,
// polynomial x^16+x^14+x^13+x^11+1, right-shifting.
module lfsr16
  import game_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  logic fb;

  assign fb = q[0] ^ q[2] ^ q[3] ^ q[5];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= LFSR_SEED;
    end else begin
      q <= {fb, q[15:1]};
    end
  end

endmodule

// File: rtl/draw_pipes.sv
// draw_pipes: scrolling pipe layer composited under the bird layer.
// Tracks pipe positions, score and sticky collision; 1-clock latency.
module draw_pipes
  import game_pkg::*;
#(
  parameter int NUM_PIPES    = 3,
  parameter int PIPE_WIDTH   = 80,
  parameter int PIPE_SPACING = 300,
  parameter int GAP_H        = 200,
  parameter int SCROLL_SPEED = 2,
  parameter int BIRD_X       = 400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        game_rst,
  input  logic        play_en,
  vga_if.in           vin,
  input  logic [11:0] rgb_in,
  input  logic        valid_in,
  vga_if.out          vout,
  output logic [11:0] rgb_out,
  output logic        collision,
  output logic [7:0]  score
);

  px_t px     [NUM_PIPES];
  gy_t gy     [NUM_PIPES];
  px_t px_nxt [NUM_PIPES];
  gy_t gy_nxt [NUM_PIPES];

  logic [NUM_PIPES-1:0] hit;
  logic [NUM_PIPES-1:0] pass;
  logic [15:0] lfsr;
  logic [11:0] h, v;
  logic [11:0] rgb_nxt;
  logic [7:0]  score_nxt;
  logic        tick, blank, is_pipe;
  logic        lfsr_unused;

  lfsr16 u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr)
  );

  assign lfsr_unused = ^lfsr[15:8];

  assign h       = {1'b0, vin.hcount};
  assign v       = {1'b0, vin.vcount};
  assign tick    = (vin.hcount == '0) && (vin.vcount == '0);
  assign blank   = vin.hblnk | vin.vblnk;
  assign is_pipe = |hit;

  always_comb begin
    for (int i = 0; i < NUM_PIPES; i++) begin
      hit[i] = (h >= {1'b0, px[i]}) &&
               (h < right_edge(px[i], PIPE_WIDTH)) &&
               ((v < {2'b0, gy[i]}) ||
                (v >= {2'b0, gy[i]} + 12'(GAP_H)));
    end
  end

  always_comb begin
    score_nxt = score;
    for (int i = 0; i < NUM_PIPES; i++) begin
      px_nxt[i] = px[i];
      gy_nxt[i] = gy[i];
      pass[i]   = 1'b0;
      if (tick && play_en) begin
        if (px[i] > px_t'(SCROLL_SPEED)) begin
          px_nxt[i] = px[i] - px_t'(SCROLL_SPEED);
        end else begin
          // wrap behind the last pipe, keeping the sub-step remainder
          px_nxt[i] = px[i] - px_t'(SCROLL_SPEED)
                    + px_t'(NUM_PIPES * PIPE_SPACING);
          gy_nxt[i] = gy_t'(GY_BASE) + gy_t'(lfsr[7:0]);
        end
        pass[i] =
          (right_edge(px[i], PIPE_WIDTH) > 12'(BIRD_X)) &&
          (right_edge(px_nxt[i], PIPE_WIDTH) <= 12'(BIRD_X));
      end
      if (pass[i] && score_nxt != 8'hFF) begin
        score_nxt = score_nxt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_PIPES; i++) begin
        px[i] <= px_t'(PIPE_X0 + i * PIPE_SPACING);
        gy[i] <= gy_t'(PIPE_GY0);
      end
      score     <= '0;
      collision <= 1'b0;
    end else if (game_rst) begin
      for (int i = 0; i < NUM_PIPES; i++) begin
        px[i] <= px_t'(PIPE_X0 + i * PIPE_SPACING);
        gy[i] <= gy_t'(PIPE_GY0);
      end
      score     <= '0;
      collision <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_PIPES; i++) begin
        px[i] <= px_nxt[i];
        gy[i] <= gy_nxt[i];
      end
      score <= score_nxt;
      if (play_en && !blank && valid_in && is_pipe) begin
        collision <= 1'b1;
      end
    end
  end

  always_comb begin
    if (blank) begin
      rgb_nxt = COL_BLANK;
    end else if (valid_in) begin
      rgb_nxt = rgb_in;
    end else if (is_pipe) begin
      rgb_nxt = COL_PIPE;
    end else begin
      rgb_nxt = COL_SKY;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb_out     <= COL_BLANK;
      vout.hcount <= '0;
      vout.hsync  <= 1'b0;
      vout.hblnk  <= 1'b0;
      vout.vcount <= '0;
      vout.vsync  <= 1'b0;
      vout.vblnk  <= 1'b0;
    end else begin
      rgb_out     <= rgb_nxt;
      vout.hcount <= vin.hcount;
      vout.hsync  <= vin.hsync;
      vout.hblnk  <= vin.hblnk;
      vout.vcount <= vin.vcount;
      vout.vsync  <= vin.vsync;
      vout.vblnk  <= vin.vblnk;
    end
  end

endmodule

// File: tb/tb_draw_pipes.sv
// tb_draw_pipes: random and directed stimulus for draw_pipes,
// checked every clock against a behavioural game model.
module tb_draw_pipes;
  import game_pkg::*;

  localparam int NP  = 3;
  localparam int W   = 80;
  localparam int SP  = 300;
  localparam int GAP = 200;
  localparam int SPD = 2;
  localparam int BX  = 400;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        game_rst = 1'b0;
  logic        play_en = 1'b0;
  logic        valid_in = 1'b0;
  logic [11:0] rgb_in = '0;
  logic [11:0] rgb_out;
  logic        collision;
  logic [7:0]  score;

  vga_if vin ();
  vga_if vout ();

  draw_pipes dut (
    .clk       (clk),
    .rst       (rst),
    .game_rst  (game_rst),
    .play_en   (play_en),
    .vin       (vin),
    .rgb_in    (rgb_in),
    .valid_in  (valid_in),
    .vout      (vout),
    .rgb_out   (rgb_out),
    .collision (collision),
    .score     (score)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int          m_px [NP];
  int          m_gy [NP];
  int          m_score;
  bit          m_col;
  logic [15:0] m_lfsr;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Polynomial taps 16,14,13,11 in a right-shifting register.
  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    int taps [4] = '{16, 14, 13, 11};
    logic fb = 1'b0;
    foreach (taps[k]) fb ^= q[16 - taps[k]];
    return {fb, q[15:1]};
  endfunction

  function automatic bit model_pipe(input int h, input int v);
    for (int i = 0; i < NP; i++) begin
      if (h >= m_px[i] && h < m_px[i] + W &&
          (v < m_gy[i] || v >= m_gy[i] + GAP))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      m_px[i] = PIPE_X0 + i * SP;
      m_gy[i] = PIPE_GY0;
    end
    m_score = 0;
    m_col   = 1'b0;
  endtask

  // Called at posedge+1; drives one pixel, returns at next posedge+1.
  task automatic step(input int h, input int v,
                      input logic [11:0] rgb, input bit vld,
                      input bit play, input bit grst);
    bit blank, pipe;
    int exp_rgb, old;
    blank = (h >= H_ACTIVE) || (v >= V_ACTIVE);
    vin.hcount = 11'(h);
    vin.vcount = 11'(v);
    vin.hblnk  = (h >= H_ACTIVE);
    vin.vblnk  = (v >= V_ACTIVE);
    vin.hsync  = (h >= 840 && h < 968);
    vin.vsync  = (v >= 601 && v < 605);
    rgb_in   = rgb;
    valid_in = vld;
    play_en  = play;
    game_rst = grst;
    pipe = model_pipe(h, v);
    exp_rgb = blank ? 0 : vld ? int'(rgb) : pipe ? 'h2A2 : 'h4CF;
    if (grst) begin
      model_reset();
    end else begin
      if (play && vld && pipe && !blank) m_col = 1'b1;
      if (h == 0 && v == 0 && play) begin
        for (int i = 0; i < NP; i++) begin
          old = m_px[i];
          if (old > SPD) m_px[i] = old - SPD;
          else begin
            m_px[i] = old - SPD + NP * SP;
            m_gy[i] = 100 + int'(m_lfsr[7:0]);
          end
          if (old + W > BX && m_px[i] + W <= BX && m_score < 255)
            m_score++;
        end
      end
    end
    m_lfsr = lfsr_next(m_lfsr);
    @(posedge clk);
    #1;
    check("rgb_out", rgb_out, exp_rgb);
    check("collision", collision, m_col);
    check("score", score, m_score);
    check("vout_h", vout.hcount, h);
    check("vout_v", vout.vcount, v);
    check("vout_blnk", {vout.hblnk, vout.vblnk},
          {30'd0, h >= H_ACTIVE, v >= V_ACTIVE});
    check("lfsr", dut.u_lfsr.q, m_lfsr);
    for (int i = 0; i < NP; i++) begin
      check("px", dut.px[i], m_px[i]);
      check("gy", dut.gy[i], m_gy[i]);
    end
  endtask

  initial begin
    logic [15:0] l_snap;
    int h, v;

    vin.hcount = 11'd100;
    vin.vcount = 11'd300;
    vin.hblnk = 1'b0;
    vin.vblnk = 1'b0;
    vin.hsync = 1'b0;
    vin.vsync = 1'b0;
    model_reset();
    m_lfsr = 16'hACE1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_rgb", rgb_out, 12'h000);
    check("rst_col", collision, 0);
    check("rst_score", score, 0);
    check("rst_vout", vout.hcount, 0);
    check("rst_lfsr", dut.u_lfsr.q, 16'hACE1);
    check("rst_px2", dut.px[2], 1400);
    rst = 1'b1;

    // frozen frame, then sky pixel
    step(100, 300, 12'h0, 0, 0, 0);
    step(0, 0, 12'h0, 0, 0, 0);
    for (int i = 0; i < NP; i++) check("frozen_px", dut.px[i], 800 + i * 300);
    step(100, 300, 12'h0, 0, 0, 0);
    check("sky", rgb_out, 12'h4CF);

    repeat (10) step(0, 0, 12'h0, 0, 1, 0);
    check("px0_10f", dut.px[0], 780);
    step(785, 100, 12'h0, 0, 1, 0);
    check("pipe_px", rgb_out, 12'h2A2);

    repeat (190) step(0, 0, 12'h0, 0, 1, 0);
    check("px0_400", dut.px[0], 400);
    step(420, 100, 12'hF00, 1, 1, 0);
    check("col_set", collision, 1);
    step(420, 100, 12'h0, 0, 1, 0);
    check("col_held", collision, 1);

    // restart coinciding with a frame tick
    step(0, 0, 12'h0, 0, 1, 1);
    check("grst_px0", dut.px[0], 800);
    check("grst_col", collision, 0);

    repeat (240) step(0, 0, 12'h0, 0, 1, 0);
    check("score_once", score, 1);
    step(0, 0, 12'h0, 0, 1, 0);
    check("score_hold", score, 1);
    repeat (158) step(0, 0, 12'h0, 0, 1, 0);
    check("px0_2", dut.px[0], 2);
    l_snap = m_lfsr;
    step(0, 0, 12'h0, 0, 1, 0);
    check("wrap_px0", dut.px[0], 900);
    check("wrap_gy0", dut.gy[0], 100 + int'(l_snap[7:0]));

    for (int k = 0; k < 3000; k++) begin
      h = $urandom_range(0, 1599);
      v = $urandom_range(0, 699);
      if ($urandom_range(0, 3) == 0) begin
        h = 0;
        v = 0;
      end
      step(h, v, 12'($urandom), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) != 0), ($urandom_range(0, 499) == 0));
    end

    step(5, 5, 12'h0, 0, 1, 1);
    for (int k = 0; k < 60000 && m_score < 255; k++)
      step(0, 0, 12'h0, 0, 1, 0);
    repeat (400) step(0, 0, 12'h0, 0, 1, 0);
    check("score_sat", score, 255);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
